// File: rtl/board_pkg.sv
// board_pkg: shared FSM states, line-clear score table and default board geometry
//   DEF_ROWS / DEF_COLS / DEF_HIDDEN_ROWS : default board parameters
//   state_t                               : lock-sequence FSM state
//   score_of(k)                           : score awarded for k lines cleared by one lock
package board_pkg;
    localparam int DEF_ROWS = 24;
    localparam int DEF_COLS = 16;
    localparam int DEF_HIDDEN_ROWS = 2;
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;
    function automatic logic [3:0] score_of(input logic [2:0] k);
        return k == 3'd1 ? 4'd1 : k == 3'd2 ? 4'd3 : k == 3'd3 ? 4'd5 : k == 3'd4 ? 4'd8 : 4'd0;
    endfunction
endpackage

// File: rtl/sat_accum.sv
// sat_accum: saturating accumulator of parametrised width
//   Clk, Reset : clock, synchronous active-high reset (clears acc)
//   en         : add inc to acc this cycle
//   inc        : increment value
//   acc        : running total, sticks at all-ones
module sat_accum #(
    parameter int W = 7,
    parameter int IW = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          en,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  acc
);
    localparam int SW = (W > IW ? W : IW) + 1;
    logic [SW-1:0] sum;
    logic [SW-1:0] max_v;
    assign max_v = SW'({W{1'b1}});
    assign sum = SW'(acc) + SW'(inc);
    always_ff @(posedge Clk) begin
        if (Reset) acc <= '0;
        else if (en) acc <= sum > max_v ? '1 : sum[W-1:0];
    end
endmodule

// File: rtl/static_board_engine.sv
// static_board_engine: locks four-cell pieces into a flop-array board and clears full rows
//   Clk, Reset        : clock, synchronous active-high reset
//   wr_en/wr_row/wr_col : lock request with four cell coordinates
//   wr_ready          : IDLE and not lost
//   board             : occupancy, bit r*COLS+c
//   busy, done        : sequence in progress / one-cycle completion pulse
//   lines_now         : lines cleared by the last lock
//   line_count, score : saturating totals
//   lose              : sticky game over
module static_board_engine
    import board_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int HIDDEN_ROWS = DEF_HIDDEN_ROWS,
    parameter int LINE_W = 6,
    parameter int SCORE_W = 7
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           wr_en,
    input  logic [3:0][$clog2(ROWS)-1:0]   wr_row,
    input  logic [3:0][$clog2(COLS)-1:0]   wr_col,
    output logic                           wr_ready,
    output logic [ROWS*COLS-1:0]           board,
    output logic                           busy,
    output logic                           done,
    output logic [2:0]                     lines_now,
    output logic [LINE_W-1:0]              line_count,
    output logic [SCORE_W-1:0]             score,
    output logic                           lose
);
    localparam int RW = $clog2(ROWS);
    localparam int N = ROWS * COLS;
    state_t state;
    logic [RW-1:0] scan_row;
    logic [2:0] cnt;
    logic [N-1:0] nb;
    logic [N-1:0] low_mask;
    logic [COLS-1:0] row_sel;
    logic accept, row_full, finish;
    assign wr_ready = state == IDLE && !lose;
    assign busy = state != IDLE;
    assign accept = wr_en && wr_ready;
    assign row_sel = COLS'(board >> (32'(scan_row) * COLS));
    assign row_full = &row_sel;
    assign finish = state == SCAN && !row_full && scan_row == '0;
    // rows 0..scan_row take the row above them; rows below scan_row are untouched
    assign low_mask = ~({N{1'b1}} << ((32'(scan_row) + 1) * COLS));
    always_comb begin
        nb = board;
        for (int i = 0; i < 4; i++)
            if (accept && 32'(wr_row[i]) < ROWS && 32'(wr_col[i]) < COLS)
                nb = nb | (N'(1) << (32'(wr_row[i]) * COLS + 32'(wr_col[i])));
        if (state == SHIFT) nb = ((board << COLS) & low_mask) | (board & ~low_mask);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            board <= '0;
            scan_row <= '0;
            cnt <= '0;
            done <= 1'b0;
            lines_now <= '0;
            lose <= 1'b0;
        end else begin
            board <= nb;
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state <= SCAN;
                    scan_row <= RW'(ROWS - 1);
                    cnt <= '0;
                end
                SCAN: if (row_full) state <= SHIFT;
                else if (scan_row != '0) scan_row <= scan_row - 1'b1;
                else begin
                    // results are registered on entry to DONE so they coincide with the done pulse
                    state <= DONE;
                    done <= 1'b1;
                    lines_now <= cnt;
                    lose <= |board[HIDDEN_ROWS*COLS-1:0];
                end
                SHIFT: begin
                    state <= SCAN;
                    cnt <= cnt + 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
    sat_accum #(.W(LINE_W), .IW(3)) u_lines (
        .Clk(Clk), .Reset(Reset), .en(finish), .inc(cnt), .acc(line_count)
    );
    sat_accum #(.W(SCORE_W), .IW(4)) u_score (
        .Clk(Clk), .Reset(Reset), .en(finish), .inc(score_of(cnt)), .acc(score)
    );
endmodule

// File: tb/tb_static_board_engine.sv
// tb_static_board_engine: randomized and directed checks of two board engine instances against a line-removal model
module tb_static_board_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic wr_en_a, ready_a, busy_a, done_a, lose_a;
    logic [3:0][4:0] wr_row_a;
    logic [3:0][3:0] wr_col_a;
    logic [383:0] board_a;
    logic [2:0] now_a;
    logic [5:0] lc_a;
    logic [6:0] sc_a;
    logic wr_en_b, ready_b, busy_b, done_b, lose_b;
    logic [3:0][2:0] wr_row_b;
    logic [3:0][1:0] wr_col_b;
    logic [31:0] board_b;
    logic [2:0] now_b;
    logic [4:0] lc_b;
    logic [6:0] sc_b;
    static_board_engine u_a (
        .Clk(clk), .Reset(rst), .wr_en(wr_en_a), .wr_row(wr_row_a), .wr_col(wr_col_a),
        .wr_ready(ready_a), .board(board_a), .busy(busy_a), .done(done_a),
        .lines_now(now_a), .line_count(lc_a), .score(sc_a), .lose(lose_a)
    );
    static_board_engine #(.ROWS(8), .COLS(4), .HIDDEN_ROWS(2), .LINE_W(5), .SCORE_W(7)) u_b (
        .Clk(clk), .Reset(rst), .wr_en(wr_en_b), .wr_row(wr_row_b), .wr_col(wr_col_b),
        .wr_ready(ready_b), .board(board_b), .busy(busy_b), .done(done_b),
        .lines_now(now_b), .line_count(lc_b), .score(sc_b), .lose(lose_b)
    );
    int sel = 0;
    logic [383:0] o_board;
    logic o_ready, o_busy, o_done, o_lose;
    logic [2:0] o_now;
    logic [5:0] o_lc;
    logic [6:0] o_sc;
    assign o_board = sel == 1 ? {352'b0, board_b} : board_a;
    assign o_ready = sel == 1 ? ready_b : ready_a;
    assign o_busy = sel == 1 ? busy_b : busy_a;
    assign o_done = sel == 1 ? done_b : done_a;
    assign o_lose = sel == 1 ? lose_b : lose_a;
    assign o_now = sel == 1 ? now_b : now_a;
    assign o_lc = sel == 1 ? {1'b0, lc_b} : lc_a;
    assign o_sc = sel == 1 ? sc_b : sc_a;
    int checks = 0;
    int errors = 0;
    bit m[2][24][16];
    int m_rows[2] = '{24, 8};
    int m_cols[2] = '{16, 4};
    int m_lmax[2] = '{63, 31};
    int m_smax[2] = '{127, 127};
    int m_now[2], m_lines[2], m_score[2];
    bit m_lose[2];
    int tbl[5] = '{0, 1, 3, 5, 8};

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 24; r++) for (int c = 0; c < 16; c++) m[s][r][c] = 1'b0;
            m_now[s] = 0; m_lines[s] = 0; m_score[s] = 0; m_lose[s] = 1'b0;
        end
    endtask

    // place the cells, then remove every full row and let the rest fall into place
    task automatic model_lock(input int s, input int r[4], input int c[4], output int k);
        bit nxt[24][16];
        int dst;
        bit full;
        for (int i = 0; i < 4; i++)
            if (r[i] < m_rows[s] && c[i] < m_cols[s]) m[s][r[i]][c[i]] = 1'b1;
        for (int row = 0; row < 24; row++) for (int col = 0; col < 16; col++) nxt[row][col] = 1'b0;
        k = 0;
        dst = m_rows[s] - 1;
        for (int row = m_rows[s] - 1; row >= 0; row--) begin
            full = 1'b1;
            for (int col = 0; col < m_cols[s]; col++) full &= m[s][row][col];
            if (full) k++;
            else begin
                for (int col = 0; col < m_cols[s]; col++) nxt[dst][col] = m[s][row][col];
                dst--;
            end
        end
        for (int row = 0; row < 24; row++) for (int col = 0; col < 16; col++) m[s][row][col] = nxt[row][col];
        m_now[s] = k;
        m_lines[s] = m_lines[s] + k > m_lmax[s] ? m_lmax[s] : m_lines[s] + k;
        m_score[s] = m_score[s] + tbl[k] > m_smax[s] ? m_smax[s] : m_score[s] + tbl[k];
        for (int row = 0; row < 2; row++) for (int col = 0; col < m_cols[s]; col++)
            if (m[s][row][col]) m_lose[s] = 1'b1;
    endtask

    function automatic logic [383:0] exp_board(input int s);
        logic [383:0] v = '0;
        for (int r = 0; r < m_rows[s]; r++) for (int c = 0; c < m_cols[s]; c++)
            if (m[s][r][c]) v = v | (384'(1) << (r * m_cols[s] + c));
        return v;
    endfunction

    task automatic drive(input int s, input int r[4], input int c[4]);
        for (int i = 0; i < 4; i++) begin
            if (s == 0) begin wr_row_a[i] = 5'(r[i]); wr_col_a[i] = 4'(c[i]); end
            else begin wr_row_b[i] = 3'(r[i]); wr_col_b[i] = 2'(c[i]); end
        end
        if (s == 0) wr_en_a = 1'b1; else wr_en_b = 1'b1;
    endtask

    task automatic release_wr();
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    task automatic check_results(input int s, input string tag);
        logic [383:0] eb = exp_board(s);
        checks++; if (o_now !== 3'(m_now[s])) begin errors++; $display("FAIL %s lines_now: got %0d want %0d", tag, o_now, m_now[s]); end
        checks++; if (o_lc !== 6'(m_lines[s])) begin errors++; $display("FAIL %s line_count: got %0d want %0d", tag, o_lc, m_lines[s]); end
        checks++; if (o_sc !== 7'(m_score[s])) begin errors++; $display("FAIL %s score: got %0d want %0d", tag, o_sc, m_score[s]); end
        checks++; if (o_lose !== m_lose[s]) begin errors++; $display("FAIL %s lose: got %0b want %0b", tag, o_lose, m_lose[s]); end
        checks++; if (o_board !== eb) begin errors++; $display("FAIL %s board: got %h want %h", tag, o_board, eb); end
    endtask

    task automatic lock(input int s, input int r[4], input int c[4], input bit hold);
        int k, lat, got;
        bit bad_busy;
        int jr[4], jc[4];
        sel = s;
        jr = s == 0 ? '{10, 10, 11, 11} : '{2, 3, 4, 5};
        jc = '{0, 1, 2, 3};
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_before_lock s=%0d: got %0b want 1", s, o_ready); end
        drive(s, r, c);
        model_lock(s, r, c, k);
        lat = m_rows[s] + 2 * k + 1;
        @(posedge clk); #1;
        if (hold) drive(s, jr, jc); else release_wr();
        got = 0;
        bad_busy = 1'b0;
        for (int cyc = 1; cyc <= lat + 4 && got == 0; cyc++) begin
            @(negedge clk);
            if (o_done === 1'b1) got = cyc;
            else if (o_busy !== 1'b1) bad_busy = 1'b1;
        end
        release_wr();
        checks++; if (got != lat) begin errors++; $display("FAIL latency s=%0d: got %0d want %0d", s, got, lat); end
        checks++; if (bad_busy) begin errors++; $display("FAIL busy_during_lock s=%0d: got 0 want 1", s); end
        check_results(s, "lock");
        @(negedge clk);
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL after_done s=%0d: got done=%0b busy=%0b want 0 0", s, o_done, o_busy); end
    endtask

    task automatic do_reset();
        release_wr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        release_wr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = s;
            #1;
            checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done s=%0d: got %0b %0b want 0 0", s, o_busy, o_done); end
            check_results(s, "reset");
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b %0b want 1 1", ready_a, ready_b); end
    endtask

    task automatic test_no_clear();
        do_reset();
        lock(0, '{23, 23, 23, 23}, '{0, 1, 2, 3}, 1'b0);
        checks++; if (o_board[371:368] !== 4'hF || o_now !== 3'd0) begin errors++; $display("FAIL no_clear: got bits=%h lines=%0d want f 0", o_board[371:368], o_now); end
    endtask

    task automatic test_single_clear();
        do_reset();
        for (int j = 0; j < 3; j++) lock(0, '{23, 23, 23, 23}, '{4*j, 4*j+1, 4*j+2, 4*j+3}, 1'b0);
        lock(0, '{23, 23, 23, 23}, '{12, 13, 14, 15}, 1'b1);
        checks++; if (o_now !== 3'd1 || o_lc !== 6'd1 || o_sc !== 7'd1 || o_board !== '0) begin errors++; $display("FAIL single_clear: got now=%0d lc=%0d sc=%0d want 1 1 1 empty", o_now, o_lc, o_sc); end
    endtask

    task automatic test_tetris();
        int r[4], c[4];
        do_reset();
        for (int g = 0; g < 15; g++) begin
            for (int i = 0; i < 4; i++) begin
                r[i] = 20 + (4 * g + i) / 15;
                c[i] = (4 * g + i) % 15 < 5 ? (4 * g + i) % 15 : (4 * g + i) % 15 + 1;
            end
            lock(0, r, c, 1'b0);
        end
        lock(0, '{20, 21, 22, 23}, '{5, 5, 5, 5}, 1'b0);
        checks++; if (o_now !== 3'd4 || o_sc !== 7'd8 || o_board !== '0) begin errors++; $display("FAIL tetris: got now=%0d sc=%0d board=%h want 4 8 0", o_now, o_sc, o_board); end
    endtask

    task automatic test_random();
        int r[4], c[4];
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin r[i] = $urandom_range(27, 18); c[i] = $urandom_range(15, 0); end
            lock(0, r, c, 1'($urandom_range(1, 0)));
        end
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin r[i] = $urandom_range(7, 2); c[i] = $urandom_range(3, 0); end
            lock(1, r, c, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic b_tetris();
        lock(1, '{4, 4, 4, 5}, '{1, 2, 3, 1}, 1'b0);
        lock(1, '{5, 5, 6, 6}, '{2, 3, 1, 2}, 1'b0);
        lock(1, '{6, 7, 7, 7}, '{3, 1, 2, 3}, 1'b0);
        lock(1, '{4, 5, 6, 7}, '{0, 0, 0, 0}, 1'b1);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int g = 0; g < 15; g++) b_tetris();
        for (int g = 0; g < 4; g++) lock(1, '{7, 7, 7, 7}, '{0, 1, 2, 3}, 1'b0);
        checks++; if (o_sc !== 7'd124 || o_lc !== 6'd31) begin errors++; $display("FAIL sat_124: got sc=%0d lc=%0d want 124 31", o_sc, o_lc); end
        lock(1, '{7, 7, 7, 7}, '{0, 1, 2, 3}, 1'b0);
        checks++; if (o_sc !== 7'd125) begin errors++; $display("FAIL sat_125: got %0d want 125", o_sc); end
        b_tetris();
        checks++; if (o_sc !== 7'd127 || o_lc !== 6'd31) begin errors++; $display("FAIL sat_127: got sc=%0d lc=%0d want 127 31", o_sc, o_lc); end
    endtask

    task automatic test_reset_in_shift();
        sel = 1;
        @(negedge clk);
        drive(1, '{7, 7, 7, 7}, '{0, 1, 2, 3});
        @(posedge clk); #1;
        release_wr();
        repeat (2) @(negedge clk);
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL shift_busy: got %0b want 1", busy_b); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL shift_reset_busy_done: got %0b %0b want 0 0", busy_b, done_b); end
        check_results(1, "shift_reset");
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL shift_reset_ready: got %0b want 1", ready_b); end
        lock(1, '{7, 7, 7, 6}, '{0, 1, 2, 3}, 1'b0);
        lock(1, '{6, 6, 6, 5}, '{1, 2, 3, 0}, 1'b0);
    endtask

    task automatic test_lose();
        logic [383:0] eb;
        do_reset();
        lock(0, '{1, 2, 3, 4}, '{7, 7, 7, 7}, 1'b0);
        checks++; if (o_lose !== 1'b1) begin errors++; $display("FAIL lose_set: got %0b want 1", o_lose); end
        eb = exp_board(0);
        drive(0, '{20, 20, 20, 20}, '{0, 1, 2, 3});
        repeat (6) @(negedge clk);
        release_wr();
        checks++; if (o_board !== eb || o_busy !== 1'b0 || o_ready !== 1'b0 || o_lose !== 1'b1) begin
            errors++; $display("FAIL lose_ignore: got busy=%0b ready=%0b lose=%0b board=%h want 0 0 1 %h", o_busy, o_ready, o_lose, o_board, eb);
        end
        do_reset();
        @(negedge clk);
        checks++; if (o_lose !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL lose_cleared: got lose=%0b ready=%0b want 0 1", o_lose, o_ready); end
    endtask

    initial begin
        rst = 1'b1;
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        wr_row_a = '0; wr_col_a = '0; wr_row_b = '0; wr_col_b = '0;
        test_reset();
        test_no_clear();
        test_single_clear();
        test_tetris();
        test_random();
        test_saturation();
        test_reset_in_shift();
        test_lose();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/static_board_engine.md
STATIC_BOARD_ENGINE -- requirements
Module: static_board_engine

Interface
REQ-001 SHALL have parameter ROWS, default 24, meaning board height in rows; row 0 is the top row.
REQ-002 SHALL have parameter COLS, default 16, meaning board width in columns.
REQ-003 SHALL have parameter HIDDEN_ROWS, default 2, meaning the number of top rows whose occupancy after a clear means game over.
REQ-004 SHALL have parameter LINE_W, default 6, meaning the width of the total line counter.
REQ-005 SHALL have parameter SCORE_W, default 7, meaning the width of the score accumulator.
REQ-006 Clk  input  1  system clock; all logic on posedge Clk.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  request to lock one piece (four cells) into the board.
REQ-009 wr_row  input  4x$clog2(ROWS)  row index of each of the four cells.
REQ-010 wr_col  input  4x$clog2(COLS)  column index of each of the four cells.
REQ-011 wr_ready  output  1  high only in IDLE with lose low.
REQ-012 board  output  ROWS*COLS  registered occupancy; bit r*COLS+c is row r, column c.
REQ-013 busy  output  1  high in every non-IDLE state.
REQ-014 done  output  1  one-cycle pulse at the end of each lock sequence.
REQ-015 lines_now  output  3  lines cleared by the last lock, 0..4; held until the next done.
REQ-016 line_count  output  LINE_W  total lines cleared; saturates.
REQ-017 score  output  SCORE_W  total score; saturates.
REQ-018 lose  output  1  sticky game-over flag.

Function
REQ-019 Accept: the block SHALL accept a write only when wr_en & wr_ready; wr_en at any other time SHALL be ignored without side effects.
REQ-020 On acceptance (cycle 0), the board SHALL OR in each in-range cell at the same edge; duplicate cells are harmless; a cell with row>=ROWS or col>=COLS SHALL be dropped.
REQ-021 FSM states: IDLE, SCAN, SHIFT, DONE; acceptance moves IDLE->SCAN with scan row = ROWS-1 and the per-lock count cleared.
REQ-022 SCAN tests one row per cycle: full row -> SHIFT; not full and row>0 -> decrement row, stay in SCAN; not full and row==0 -> DONE.
REQ-023 SHIFT (1 cycle) SHALL copy rows r-1..0 down to rows r..1, clear row 0, increment the per-lock count, and return to SCAN at the same row r.
REQ-024 Latency: with k full rows, done SHALL pulse at cycle ROWS+2k+1 after acceptance; busy SHALL be high for cycles 1..ROWS+2k+1.
REQ-025 DONE (1 cycle): assert done; update lines_now; add k to line_count, saturating at 2^LINE_W-1; add score table[k] (0,1,3,5,8) to score, saturating at 2^SCORE_W-1; then return to IDLE.
REQ-026 In DONE, if any bit in rows 0..HIDDEN_ROWS-1 is set, lose SHALL set in the same cycle as done and stay set until Reset; no further write SHALL be accepted.
REQ-027 The board SHALL change only on acceptance and in SHIFT.
REQ-028 Non-adjacent full rows SHALL each be cleared exactly once, including a full row revealed by a shift.
REQ-029 If Reset is asserted during SCAN or SHIFT, the partial clear SHALL be discarded and the reset values applied.

Reset
REQ-030 On Reset, the block SHALL enter IDLE and drive board=0, busy=0, done=0, lines_now=0, line_count=0, score=0, lose=0; wr_ready SHALL be 1 in the cycle after Reset deasserts.

Structure
REQ-031 Shared package board_pkg SHALL hold the FSM state enum, the score-table function, and the default ROWS/COLS/HIDDEN_ROWS constants.
REQ-032 One sub-module sat_accum SHALL provide the parametrised-width saturating add, instanced twice (line_count, score).
REQ-033 The implementation SHALL use no memory macro; the board SHALL be a flop array, and row-full SHALL be a combinational AND-reduce of the selected row.

Verification
REQ-034 Empty board; lock cells (23,0..3) -> no clear; done at cycle 25; lines_now=0; board bits 368..371 set.
REQ-035 Row 23 pre-filled except columns 12..15; lock (23,12..15) -> done at cycle 27; lines_now=1; row 23 = old row 22; line_count=1; score=1.
REQ-036 Rows 20..23 each pre-filled except column 5; lock I piece (20..23,5) -> done at cycle 33; lines_now=4; score+=8; board all zero.
REQ-037 Score at 124; clear 1 line, then 4 lines -> score 125, then 127 (saturated); line_count=31 with LINE_W=5 plus 4 lines -> 31.
REQ-038 Lock with cell (1,7) and no clear -> lose=1 with done; later wr_en ignored; board unchanged; wr_ready=0 until Reset.
REQ-039 Reset asserted in SHIFT; second instance with ROWS=8, COLS=4 -> all reset values; wr_ready=1 next cycle; parametrised latency 8+2k+1 checked.
